program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that sits upstream of `cpu`. It receives a program image as a byte stream from a serial receiver, assembles big-endian 16-bit words, and writes them into the CPU's word memory starting at address 0. It holds the CPU in reset until the image is loaded, replacing the simulation-only `$readmemb` preload on hardware builds.

## Interface
- `MEMORY_SIZE`, 32, depth of CPU memory in 16-bit words; must be ≥ 2.
- `ADDR_W`, `$clog2(MEMORY_SIZE)`, memory address width.
- `clk` in 1: system clock; all logic is rising-edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `in_valid` in 1: byte available on `in_data`.
- `in_data` in 8: received byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: one-cycle memory write strobe.
- `mem_addr` out ADDR_W: word address of the write.
- `mem_wdata` out 16: word data, `{high byte, low byte}`.
- `cpu_rst` out 1: active-high reset to `cpu`; released only on successful load.
- `load_done` out 1: sticky, image loaded.
- `load_error` out 1: sticky, image rejected.

## Operation
- A byte is accepted when `in_valid && in_ready`. No byte is consumed otherwise.
- Stream format: count high byte, count low byte (N words, 16-bit), then 2N data bytes with the high byte first. With `LOADER_CHECKSUM_EN`, one checksum byte follows the data.
- States:
  - CNT_HI: accept a byte, store it as count[15:8], go to CNT_LO.
  - CNT_LO: accept a byte, form the count. If N == 0 or N > MEMORY_SIZE, go to ERROR. Otherwise clear the word index and go to DATA_HI.
  - DATA_HI: accept a byte, latch it as the high byte, go to DATA_LO.
  - DATA_LO: accept a byte and register a write of `{hi, lo}` at the word index. Increment the index. If the index now equals N, go to CHECK (macro on) or DONE; otherwise go to DATA_HI.
  - CHECK: accept a byte. Go to DONE if it equals the running checksum, otherwise go to ERROR.
  - DONE and ERROR: terminal. Leave only through `rst`.
- `in_ready` is 1 in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHECK, and 0 in DONE and ERROR.
- Outputs by state:
  - `cpu_rst` is 1 in every state except DONE.
  - `load_done` is 1 only in DONE.
  - `load_error` is 1 only in ERROR.
- The word index is ADDR_W+1 bits wide so it can hold the value MEMORY_SIZE. `mem_addr` carries its low ADDR_W bits. Writes never exceed address MEMORY_SIZE-1.
- Memory words beyond N are not written.

## Timing
- Reset values: state CNT_HI, `in_ready` 1, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_rst` 1, `load_done` 0, `load_error` 0, index 0, checksum 0.
- Throughput: one byte per cycle; a byte may be accepted on every consecutive cycle.
- Write latency: `mem_we` pulses for exactly one cycle, in the cycle after the low byte is accepted. `mem_addr` and `mem_wdata` are valid in the same cycle and hold their values afterwards.
- `cpu_rst` falls in the same cycle that the final `mem_we` pulse is asserted (macro off), or in the cycle after the checksum byte is accepted (macro on). The memory is written before the CPU's first fetch because the CPU samples reset synchronously.
- Asserting `rst` mid-load aborts the load immediately. The loader returns to CNT_HI, `cpu_rst` goes to 1, and any partial image is left in memory.
- Idle gaps (`in_valid` = 0) in any state are tolerated indefinitely. There is no timeout.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A running 8-bit XOR is kept over all 2N data bytes; the count bytes are excluded.
  - The CHECK state is present. A mismatch gives ERROR with `cpu_rst` held at 1.
  - The checksum register clears on `rst` and on entry to DATA_HI from CNT_LO.
- Undefined:
  - There is no CHECK state and no checksum register.
  - DATA_LO goes directly to DONE after the Nth word.

## Test plan
- Macro off, MEMORY_SIZE 32, stream 00 02 12 34 AB CD with `in_valid` held high:
  - Required: `mem_we` pulses with (0, 0x1234) and then (1, 0xABCD).
  - `cpu_rst` falls with the second pulse and `load_done` = 1.
- Count 00 00, and separately count 00 21 with MEMORY_SIZE 32:
  - Required: ERROR after the second byte, `load_error` = 1, `in_ready` = 0, no `mem_we`, `cpu_rst` stays 1.
- Macro on, stream 00 01 F0 0F FF:
  - Required: DONE and write (0, 0xF00F).
  - Repeating with checksum byte 00 instead gives ERROR with `cpu_rst` = 1.
- Random `in_valid` gaps over a 32-word image:
  - Required: all 32 writes in order with correct data and addresses 0..31.
  - `in_ready` drops after the last byte; extra bytes are ignored.
- Drop `rst` to 0 after 3 data bytes, release it, and send a fresh 1-word image:
  - Required: all outputs return to their reset values asynchronously.
  - The new image loads from address 0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: boots the CPU by streaming a big-endian word image into its memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
  parameter int MEMORY_SIZE = 32,
  parameter int ADDR_W = $clog2(MEMORY_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam logic [15:0] MEM_N = 16'(MEMORY_SIZE);

  state_e          state_q;
  logic [15:0]     cnt_q;
  logic [7:0]      hi_q;
  logic [ADDR_W:0] idx_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic [15:0]     cnt_d;
  logic [ADDR_W:0] idx_d;
  logic            last;
  logic            bad_cnt;
  logic            take;

  assign cnt_d   = {cnt_q[15:8], in_data};
  assign idx_d   = idx_q + (ADDR_W+1)'(1);
  assign last    = (16'(idx_d) == cnt_q);
  assign bad_cnt = (cnt_d == 16'd0) || (cnt_d > MEM_N);
  assign take    = in_valid && in_ready;

  // Outputs are registered alongside the state, so they change with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CNT_HI;
      cnt_q      <= '0;
      hi_q       <= '0;
      idx_q      <= '0;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (take) begin
        case (state_q)
          CNT_HI: begin
            cnt_q[15:8] <= in_data;
            state_q     <= CNT_LO;
          end
          CNT_LO: begin
            if (bad_cnt) begin
              state_q    <= ERROR;
              in_ready   <= 1'b0;
              load_error <= 1'b1;
            end else begin
              cnt_q   <= cnt_d;
              idx_q   <= '0;
              state_q <= DATA_HI;
`ifdef LOADER_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end
          end
          DATA_HI: begin
            hi_q    <= in_data;
            state_q <= DATA_LO;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ in_data;
`endif
          end
          DATA_LO: begin
            mem_we    <= 1'b1;
            mem_addr  <= idx_q[ADDR_W-1:0];
            mem_wdata <= {hi_q, in_data};
            idx_q     <= idx_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_q ^ in_data;
            state_q   <= last ? CHECK : DATA_HI;
`else
            if (last) begin
              state_q   <= DONE;
              in_ready  <= 1'b0;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_q <= DATA_HI;
            end
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            in_ready <= 1'b0;
            if (in_data == csum_q) begin
              state_q   <= DONE;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_q    <= ERROR;
              load_error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: header table, hand-timed sequences and random images
// checked against a queue-based model of the expected memory writes.
module tb_program_loader;

  localparam int MS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_error;

  int n_checks = 0;
  int n_fail = 0;

  logic [4:0]  wa[$];
  logic [15:0] wd[$];

  always #5 clk = ~clk;

  program_loader #(.MEMORY_SIZE(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_error(load_error)
  );

  always @(posedge clk)
    if (rst && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 1);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_cpurst"}, 32'(cpu_rst), 1);
    chk({tag, "_done"}, 32'(load_done), 0);
    chk({tag, "_err"}, 32'(load_error), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
  endtask

  // Model: N valid words produce writes (i, word[i]); outcome from the
  // count range and, when enabled, the XOR of the data bytes.
  task automatic run_image(input int n, input bit corrupt, input int gapmax);
    logic [15:0] words[$];
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [15:0] w;
    bit          ok;
    x = 8'h00;
    do_reset();
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      words.push_back(w);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    bytes.push_back(corrupt ? (x ^ 8'h5A) : x);
    ok = !corrupt;
`else
    ok = 1'b1;
`endif
    for (int i = 0; i < 3; i++) bytes.push_back(8'($urandom));
    foreach (bytes[k]) begin
      repeat ($urandom_range(0, gapmax)) idle();
      send(bytes[k]);
    end
    repeat (3) idle();
    chk($sformatf("img%0d_done", n), 32'(load_done), 32'(ok));
    chk($sformatf("img%0d_err", n), 32'(load_error), 32'(!ok));
    chk($sformatf("img%0d_cpurst", n), 32'(cpu_rst), 32'(!ok));
    chk($sformatf("img%0d_ready", n), 32'(in_ready), 0);
    chk($sformatf("img%0d_nwr", n), wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk($sformatf("img%0d_a%0d", n, i), 32'(wa[i]), i);
      chk($sformatf("img%0d_d%0d", n, i), 32'(wd[i]), 32'(words[i]));
    end
  endtask

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    bit         err;
  } hdr_t;

  hdr_t tbl[6];

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b1};
    tbl[1] = '{8'h00, 8'h21, 1'b1};
    tbl[2] = '{8'h01, 8'h00, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1};
    tbl[4] = '{8'h00, 8'h01, 1'b0};
    tbl[5] = '{8'h00, 8'h20, 1'b0};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b1;

    foreach (tbl[i]) begin
      do_reset();
      send(tbl[i].hi);
      send(tbl[i].lo);
      idle();
      chk($sformatf("hdr%0d_err", i), 32'(load_error), 32'(tbl[i].err));
      chk($sformatf("hdr%0d_ready", i), 32'(in_ready), 32'(!tbl[i].err));
      chk($sformatf("hdr%0d_cpurst", i), 32'(cpu_rst), 1);
      idle();
      chk($sformatf("hdr%0d_nowr", i), wa.size(), 0);
    end

`ifndef LOADER_CHECKSUM_EN
    do_reset();
    send(8'h00);
    send(8'h02);
    send(8'h12);
    @(negedge clk);
    chk("t1_we_pre", 32'(mem_we), 0);
    in_valid = 1'b1;
    in_data  = 8'h34;
    @(negedge clk);
    chk("t1_we0", 32'(mem_we), 1);
    chk("t1_addr0", 32'(mem_addr), 0);
    chk("t1_data0", 32'(mem_wdata), 32'h1234);
    chk("t1_cpurst0", 32'(cpu_rst), 1);
    in_data = 8'hAB;
    @(negedge clk);
    chk("t1_we_gap", 32'(mem_we), 0);
    chk("t1_addr_hold", 32'(mem_addr), 0);
    in_data = 8'hCD;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_we1", 32'(mem_we), 1);
    chk("t1_addr1", 32'(mem_addr), 1);
    chk("t1_data1", 32'(mem_wdata), 32'hABCD);
    chk("t1_cpurst1", 32'(cpu_rst), 0);
    chk("t1_done", 32'(load_done), 1);
    chk("t1_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("t1_we_end", 32'(mem_we), 0);
    chk("t1_data_hold", 32'(mem_wdata), 32'hABCD);
    chk("t1_nwr", wa.size(), 2);
`else
    do_reset();
    send(8'h00);
    send(8'h01);
    send(8'hF0);
    send(8'h0F);
    send(8'hFF);
    chk("ck_cpurst_pre", 32'(cpu_rst), 1);
    idle();
    chk("ck_cpurst", 32'(cpu_rst), 0);
    chk("ck_done", 32'(load_done), 1);
    idle();
    chk("ck_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("ck_addr", 32'(wa[0]), 0);
      chk("ck_data", 32'(wd[0]), 32'hF00F);
    end
    do_reset();
    send(8'h00);
    send(8'h01);
    send(8'hF0);
    send(8'h0F);
    send(8'h00);
    repeat (2) idle();
    chk("ckbad_err", 32'(load_error), 1);
    chk("ckbad_cpurst", 32'(cpu_rst), 1);
    chk("ckbad_done", 32'(load_done), 0);
    chk("ckbad_ready", 32'(in_ready), 0);
`endif

    // Abort after three data bytes; the first word is already written.
    do_reset();
    send(8'h00);
    send(8'h02);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    @(posedge clk);
    #2;
    chk("ab_wdata_pre", 32'(mem_wdata), 32'hAABB);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_reset("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
`ifdef LOADER_CHECKSUM_EN
    send(8'h26);
`endif
    repeat (2) idle();
    chk("ab_done", 32'(load_done), 1);
    chk("ab_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("ab_addr", 32'(wa[0]), 0);
      chk("ab_data", 32'(wd[0]), 32'h1234);
    end

    run_image(MS, 1'b0, 2);
    run_image(1, 1'b0, 0);
    for (int t = 0; t < 4; t++) begin
`ifdef LOADER_CHECKSUM_EN
      run_image($urandom_range(1, MS), 1'($urandom_range(0, 1)), 3);
`else
      run_image($urandom_range(1, MS), 1'b0, 3);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
